// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the fetch buffer and the fetch address checker.
// Instruction memory window, exception codes and the nop encoding.
package fetch_buffer_pkg;

    localparam logic [31:0] PC_Initial = 32'h0000_3000;
    localparam logic [31:0] IM_ADDR_HI = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [31:0] INSTR_NOP  = 32'd0;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch address check: flags misaligned or out-of-window
// PCs with AdEL. Shared with the decode stage.
module fetch_addr_check
    import fetch_buffer_pkg::*;
(
    input  logic [31:0] pc,
    output logic [4:0]  exc_code,
    output logic        fault
);

    assign fault = (pc[1:0] != 2'b00)
                || (pc < PC_Initial)
                || (pc > IM_ADDR_HI);

    assign exc_code = fault ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode queue of {PC, Instr, ExcCode} entries.
// Optional FETCH_BUF_STATS_EN adds stall_cnt and bubble_cnt outputs.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             F_valid,
    input  logic [31:0]      F_PC,
    input  logic [31:0]      F_Instr,
    output logic             F_ready,
    output logic             D_valid,
    input  logic             D_ready,
    output logic [31:0]      D_PC,
    output logic [31:0]      D_Instr,
    output logic [4:0]       D_ExcCode,
    output logic [PTR_W:0]   count
`ifdef FETCH_BUF_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [4:0]  exc_mem   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;
    logic [4:0]       chk_exc;
    logic             chk_fault;

    fetch_addr_check u_check (
        .pc       (F_PC),
        .exc_code (chk_exc),
        .fault    (chk_fault)
    );

    // Ready/valid come only from registered count: no D_ready->F_ready path.
    assign F_ready = (count != FULL);
    assign D_valid = (count != '0);
    assign push    = F_valid && F_ready;
    assign pop     = D_valid && D_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; a write during flush/reset is never exposed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= F_PC;
            instr_mem[tail] <= chk_fault ? INSTR_NOP : F_Instr;
            exc_mem[tail]   <= chk_exc;
        end
    end

    assign D_PC      = D_valid ? pc_mem[head]    : 32'd0;
    assign D_Instr   = D_valid ? instr_mem[head] : INSTR_NOP;
    assign D_ExcCode = D_valid ? exc_mem[head]   : EXC_NONE;

`ifdef FETCH_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (F_valid && !F_ready) stall_cnt  <= stall_cnt + 32'd1;
            if (D_ready && !D_valid) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH 2 and DEPTH 4).
// Both instances see the same stimulus; each phase checks one of them.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        F_valid;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        D_ready;

    logic        f_ready2, d_valid2;
    logic [31:0] d_pc2, d_instr2;
    logic [4:0]  d_exc2;
    logic [1:0]  count2;

    logic        f_ready4, d_valid4;
    logic [31:0] d_pc4, d_instr4;
    logic [4:0]  d_exc4;
    logic [2:0]  count4;

`ifdef FETCH_BUF_STATS_EN
    logic [31:0] stall2, bubble2, stall4, bubble4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .F_valid(F_valid), .F_PC(F_PC), .F_Instr(F_Instr),
        .F_ready(f_ready2), .D_valid(d_valid2), .D_ready(D_ready),
        .D_PC(d_pc2), .D_Instr(d_instr2), .D_ExcCode(d_exc2),
        .count(count2)
`ifdef FETCH_BUF_STATS_EN
        , .stall_cnt(stall2), .bubble_cnt(bubble2)
`endif
    );

    fetch_buffer #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .F_valid(F_valid), .F_PC(F_PC), .F_Instr(F_Instr),
        .F_ready(f_ready4), .D_valid(d_valid4), .D_ready(D_ready),
        .D_PC(d_pc4), .D_Instr(d_instr4), .D_ExcCode(d_exc4),
        .count(count4)
`ifdef FETCH_BUF_STATS_EN
        , .stall_cnt(stall4), .bubble_cnt(bubble4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic dr);
        F_valid = fv;
        F_PC    = pc;
        F_Instr = ins;
        D_ready = dr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk("rst_count", 32'(count2), 32'd0);
        chk("rst_dvalid", 32'(d_valid2), 32'd0);
        chk("rst_fready", 32'(f_ready2), 32'd1);
        chk("rst_dpc", d_pc2, 32'd0);
        chk("rst_dinstr", d_instr2, 32'd0);
        chk("rst_dexc", 32'(d_exc2), 32'd0);
        reset = 1'b0;
        tick();

        // streaming with decode always ready
        drive(1'b1, 32'h3000, 32'h11, 1'b1);
        #1;
        chk("s_dvalid_pre", 32'(d_valid2), 32'd0);
        tick();
        chk("s_dvalid0", 32'(d_valid2), 32'd1);
        chk("s_pc0", d_pc2, 32'h3000);
        chk("s_instr0", d_instr2, 32'h11);
        drive(1'b1, 32'h3004, 32'h22, 1'b1);
        tick();
        chk("s_pc1", d_pc2, 32'h3004);
        chk("s_cnt1", 32'(count2), 32'd1);
        drive(1'b1, 32'h3008, 32'h33, 1'b1);
        tick();
        chk("s_pc2", d_pc2, 32'h3008);
        chk("s_cnt2", 32'(count2), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("s_empty", 32'(d_valid2), 32'd0);
        chk("s_empty_instr", d_instr2, 32'd0);

        // fill while decode stalled
        drive(1'b1, 32'h3000, 32'h44, 1'b0);
        tick();
        chk("f_cnt1", 32'(count2), 32'd1);
        drive(1'b1, 32'h3004, 32'h55, 1'b0);
        tick();
        chk("f_cnt2", 32'(count2), 32'd2);
        chk("f_fready0", 32'(f_ready2), 32'd0);
        drive(1'b1, 32'h3008, 32'h66, 1'b0);
        tick();
        chk("f_blocked", 32'(count2), 32'd2);
        chk("f_head0", d_pc2, 32'h3000);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("f_pop1_pc", d_pc2, 32'h3004);
        chk("f_pop1_ins", d_instr2, 32'h55);
        chk("f_fready1", 32'(f_ready2), 32'd1);
        tick();
        chk("f_drained", 32'(count2), 32'd0);

        // flush while full with push and pop requested
        drive(1'b1, 32'h3000, 32'h77, 1'b0);
        tick();
        drive(1'b1, 32'h3004, 32'h88, 1'b0);
        tick();
        chk("fl_full", 32'(count2), 32'd2);
        flush = 1'b1;
        drive(1'b1, 32'h3008, 32'h99, 1'b1);
        tick();
        flush = 1'b0;
        chk("fl_cnt", 32'(count2), 32'd0);
        chk("fl_dvalid", 32'(d_valid2), 32'd0);
        chk("fl_cnt4", 32'(count4), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("fl_nolate", 32'(count4), 32'd0);

        // address check
        drive(1'b1, 32'h3002, 32'hDEADBEEF, 1'b1);
        tick();
        chk("a_mis_exc", 32'(d_exc2), 32'd4);
        chk("a_mis_ins", d_instr2, 32'd0);
        chk("a_mis_pc", d_pc2, 32'h3002);
        drive(1'b1, 32'h2FFC, 32'hDEADBEEF, 1'b1);
        tick();
        chk("a_lo_exc", 32'(d_exc2), 32'd4);
        chk("a_lo_ins", d_instr2, 32'd0);
        drive(1'b1, 32'h7000, 32'hDEADBEEF, 1'b1);
        tick();
        chk("a_hi_exc", 32'(d_exc2), 32'd4);
        chk("a_hi_ins", d_instr2, 32'd0);
        drive(1'b1, 32'h6FFC, 32'h1234, 1'b1);
        tick();
        chk("a_top_exc", 32'(d_exc2), 32'd0);
        chk("a_top_ins", d_instr2, 32'h1234);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("a_empty_exc", 32'(d_exc2), 32'd0);

        // DEPTH=4 wrap sequence
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h3000, 32'h1000_3000, 1'b0);
        tick();
        chk("w1_cnt", 32'(count4), 32'd1);
        drive(1'b1, 32'h3004, 32'h1000_3004, 1'b0);
        tick();
        chk("w2_cnt", 32'(count4), 32'd2);
        drive(1'b1, 32'h3008, 32'h1000_3008, 1'b1);
        tick();
        chk("w3_cnt", 32'(count4), 32'd2);
        chk("w3_pc", d_pc4, 32'h3004);
        drive(1'b1, 32'h300C, 32'h1000_300C, 1'b0);
        tick();
        chk("w4_cnt", 32'(count4), 32'd3);
        drive(1'b1, 32'h3010, 32'h1000_3010, 1'b0);
        tick();
        chk("w5_cnt", 32'(count4), 32'd4);
        chk("w5_fready", 32'(f_ready4), 32'd0);
        drive(1'b1, 32'h3014, 32'h1000_3014, 1'b1);
        tick();
        chk("w6_cnt", 32'(count4), 32'd3);
        chk("w6_pc", d_pc4, 32'h3008);
        tick();
        chk("w7_cnt", 32'(count4), 32'd3);
        chk("w7_pc", d_pc4, 32'h300C);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("w8_cnt", 32'(count4), 32'd2);
        chk("w8_pc", d_pc4, 32'h3010);
        drive(1'b1, 32'h3018, 32'h1000_3018, 1'b1);
        tick();
        chk("w9_cnt", 32'(count4), 32'd2);
        chk("w9_pc", d_pc4, 32'h3014);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("w10_cnt", 32'(count4), 32'd1);
        chk("w10_pc", d_pc4, 32'h3018);
        chk("w10_ins", d_instr4, 32'h1000_3018);

        // reset during traffic
        drive(1'b1, 32'h301C, 32'h1000_301C, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_cnt", 32'(count4), 32'd0);
        chk("mr_fready", 32'(f_ready4), 32'd1);
        chk("mr_dvalid", 32'(d_valid4), 32'd0);

`ifdef FETCH_BUF_STATS_EN
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h3000, 32'h1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("st_stall", stall2, 32'd3);
        chk("st_bub0", bubble2, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("st_bubble", bubble2, 32'd4);
        chk("st_stall_hold", stall2, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Decoupling queue between the fetch stage (PC register plus combinational instruction memory) and the decode stage. It replaces a plain IF/ID register.
- Each entry holds one {PC, Instr, ExcCode} triple. The queue absorbs decode stalls so the PC register's enable comes from `F_ready` rather than a global stall.
- Checks each fetch address and tags bad addresses with an AdEL exception code, which travels down the pipeline.

Parameters:
- DEPTH, 2: number of queue entries; power of two, at least 2.
- PTR_W, 1: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all queued entries (exception entry / eret).
- F_valid  input  1  fetch stage presents a valid PC/instruction this cycle.
- F_PC  input  32  fetch address.
- F_Instr  input  32  instruction word read at F_PC.
- F_ready  output  1  queue can accept; drives the PC register enable.
- D_valid  output  1  head entry valid for decode.
- D_ready  input  1  decode consumes head this cycle (not stalled).
- D_PC  output  32  head entry PC.
- D_Instr  output  32  head entry instruction.
- D_ExcCode  output  5  head entry exception code (0 = none).
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: queue empty, `count`=0, `D_valid`=0, `F_ready`=1, `D_PC`=0, `D_Instr`=0, `D_ExcCode`=0.
- Push and pop conditions:
  - push = `F_valid` && `F_ready`.
  - pop = `D_valid` && `D_ready`.
  - Both are evaluated in the same cycle. The pointers and count update at the next edge.
- Ready and valid generation:
  - `F_ready` = (`count` != DEPTH). It depends only on registered state, so there is no combinational path from `D_ready`.
  - `D_valid` = (`count` != 0).
- Latency: a push in cycle N is visible at the head in cycle N+1 at the earliest. There is no bypass path.
- Output muxing: `D_PC`, `D_Instr` and `D_ExcCode` come directly from the head entry. When empty they read 0, so `D_Instr`=0 is a nop.
- Pointers: head and tail pointers are PTR_W bits and wrap modulo DEPTH.
- Simultaneous events:
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - When full, push cannot occur. A pop while full frees one slot next cycle, and `F_ready` rises the following cycle.
- Flush:
  - Takes highest priority over push and pop.
  - At the next edge: `count`=0, pointers reset to 0.
  - Any push or pop in the flush cycle is discarded.
- Address check, applied on push:
  - A fault is recorded if F_PC[1:0] != 0, or F_PC < 32'h0000_3000, or F_PC > 32'h0000_6FFC.
  - On a fault the entry stores ExcCode=5'd4 (AdEL) and Instr=0. PC is stored unchanged.
  - Otherwise the entry stores ExcCode=0 and F_Instr.
- Reset mid-operation: a reset asserted during any traffic empties the queue at the next edge. Reset has priority over flush.
- Storage: entry storage is not reset; only pointers and count are. Output zeroing when empty is combinational.

Optional Feature:
- Macro: `FETCH_BUF_STATS_EN`.
- When defined, two extra output ports are added:
  - stall_cnt[31:0]: increments each cycle `F_valid` && !`F_ready`.
  - bubble_cnt[31:0]: increments each cycle `D_ready` && !`D_valid`.
- Both counters are cleared by reset, are not affected by flush, and wrap at 2^32.
- When undefined, the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Constants added to the shared macro.v package:
  - PC_Initial (32'h0000_3000).
  - IM_ADDR_HI (32'h0000_6FFC).
  - EXC_ADEL (5'd4).
  - EXC_NONE (5'd0).
  - INSTR_NOP (32'd0).
- One sub-module, `fetch_addr_check`: purely combinational. Input is a 32-bit PC; outputs are 5-bit exc_code and a 1-bit fault. Decode reuses it later.

Test Plan:
- Reset, then F_valid=1 with F_PC=0x3000, 0x3004, 0x3008 and D_ready=1 throughout -> D_valid rises one cycle after the first push; D_PC follows 0x3000, 0x3004, 0x3008 in order; count stays at most 1.
- D_ready=0 while pushing 0x3000 and 0x3004 -> count=2, F_ready=0, and a third push is blocked. Raise D_ready -> heads pop in order and F_ready returns the cycle after the first pop.
- Full queue, flush=1 together with F_valid=1 and D_ready=1 -> next cycle count=0 and D_valid=0, and no entry from the flush cycle appears.
- Push F_PC=0x3002, then 0x2FFC, then 0x7000 -> each head shows D_ExcCode=4 and D_Instr=0. Push F_PC=0x6FFC -> D_ExcCode=0.
- DEPTH=4, with 10 mixed push/pop cycles -> pointers wrap and FIFO order is preserved. Reset asserted mid-stream -> count=0 and F_ready=1 next cycle.
- With FETCH_BUF_STATS_EN: hold D_ready=0 for 5 cycles with F_valid=1 at DEPTH=2 -> stall_cnt=3. Hold the queue empty with D_ready=1 for 4 cycles -> bubble_cnt=4.
